sprite_frame_decoder: RTL and testbench
=======================================

# sprite_frame_decoder

Consumer end of the 4-bit sprite `motion` code produced by the steampunk sprite state machine. Samples `motion` once per video frame and rate-limits animation so a frame is shown for at least `HOLD_FRAMES` vsyncs, which removes flicker. Advances and clamps the sprite's horizontal position, then emits the sprite-ROM base address, facing and mirror controls to the pixel renderer.

## Interface
- `HOLD_FRAMES`, 4: minimum frame ticks between same-direction animation commits (1..15).
- `STEP`, 2: pixels moved per animation advance.
- `X_INIT`, 320: reset x position.
- `X_MIN`, 0: left clamp bound.
- `X_MAX`, 623: right clamp bound.
- `FRAME_WORDS`, 256: ROM words per sprite frame.
- `ADDR_W`, 12: ROM address width.

Ports:
- `Clk`, in, 1: system clock.
- `Reset`, in, 1: asynchronous, active-high reset.
- `frame_tick`, in, 1: one-cycle pulse per vsync.
- `motion`, in, 4: {right, left, frame_idx[1:0]}; valid directions are 2'b10 (right) and 2'b01 (left).
- `sprite_x`, out, 10: sprite left edge, in pixels.
- `frame_idx`, out, 2: displayed animation frame.
- `facing`, out, 1: 0 = right, 1 = left.
- `mirror`, out, 1: renderer flips horizontally.
- `rom_base`, out, ADDR_W: first ROM word of the displayed frame.
- `frame_valid`, out, 1: one-cycle pulse on every commit.

## Operation
- Reset values: `sprite_x`=X_INIT, `frame_idx`=0, `facing`=0, `mirror`=0, `rom_base`=0, `frame_valid`=0. Internal state: `hold_cnt`=0, state=IDLE, `m_q`=4'b1000.
- FSM states are IDLE, DECODE and COMMIT.
- IDLE:
  - On `frame_tick`, latch `motion` into `m_q`.
  - Increment `hold_cnt`, saturating at HOLD_FRAMES-1.
  - Go to DECODE.
- DECODE: classify `m_q`.
  - Invalid direction (2'b00 or 2'b11): discard, go to IDLE.
  - Direction differs from `facing`: commit as a turn, go to COMMIT.
  - Same direction, `m_q[1:0]` == `frame_idx`: no change, go to IDLE.
  - Same direction, new index, `hold_cnt` == HOLD_FRAMES-1: advance, go to COMMIT.
  - Same direction, new index, hold not yet elapsed: go to IDLE and keep the old frame.
- COMMIT:
  - Load `facing` and `frame_idx` from `m_q`.
  - Update `rom_base` and `mirror`.
  - Pulse `frame_valid`.
  - Clear `hold_cnt`.
  - Return to IDLE.
- Position updates happen only on an advance commit; a turn commit never moves the sprite.
  - Right: `sprite_x` = min(`sprite_x`+STEP, X_MAX).
  - Left: `sprite_x` = max(`sprite_x`-STEP, X_MIN).
  - Compute in 11 bits so the result never wraps.
- `frame_tick` arriving in DECODE or COMMIT is ignored.

## Timing
- Tick at cycle T: `m_q` is valid at T+1 (DECODE). `sprite_x`, `frame_idx`, `facing`, `rom_base`, `mirror` and `frame_valid` update together at T+2.
- `frame_valid` is high for exactly one cycle per commit.
- All outputs are registered and hold their value between commits.
- Reset mid-COMMIT: all outputs return to reset values asynchronously, and no `frame_valid` pulse follows.

## Configuration
- `SPRITE_MIRROR_EN` defined: the ROM holds only the 4 right-facing frames.
  - `rom_base` = `frame_idx`*FRAME_WORDS.
  - `mirror` = `facing`.
- `SPRITE_MIRROR_EN` undefined: the ROM holds 8 frames.
  - `rom_base` = {`facing`,`frame_idx`}*FRAME_WORDS.
  - `mirror` is tied to 0.

## Test plan
All scenarios use the default parameters unless stated.
- Reset, then idle ticks with `motion`=4'b1000 -> `sprite_x`=320, `rom_base`=0, no `frame_valid` pulses.
- Hold `motion`=4'b1001 for 4 ticks -> first commit on the 4th tick at T+2: `frame_idx`=1, `sprite_x`=322, `rom_base`=256, single `frame_valid` pulse.
- Right-facing state, apply `motion`=4'b0101 -> commit on the next tick without waiting for hold.
  - Result: `facing`=1, `sprite_x` unchanged.
  - `rom_base`=1280 without the macro; `rom_base`=256 and `mirror`=1 with it.
- Left movement starting at `sprite_x`=1 -> clamps to 0 and stays at 0 on later advances. Right movement starting at 622 -> 623.
- `motion`=4'b1100 or 4'b0000 on a tick -> no output change, no `frame_valid`.
- Assert `Reset` in the COMMIT cycle -> outputs at reset values on the same edge, no `frame_valid` afterwards. A second `frame_tick` at T+1 is ignored.

Source files
------------

// File: rtl/sprite_frame_decoder.sv
`timescale 1ns/1ps
// sprite_frame_decoder
// ---------------------------------------------------------------------------
// Consumer end of the 4-bit sprite motion code. Samples `motion` once per
// frame tick, rate-limits same-direction animation to one commit per
// HOLD_FRAMES ticks, advances and clamps the horizontal position, and drives
// the sprite-ROM base address plus facing/mirror controls to the renderer.
//
// Build option: define SPRITE_MIRROR_EN when the ROM holds only the four
// right-facing frames; the renderer then mirrors left-facing frames.
// Without it the ROM holds eight frames (right bank, then left bank) and
// mirror stays 0.
//
// Ports
//   Clk         in   1       system clock
//   Reset       in   1       asynchronous active-high reset
//   frame_tick  in   1       one-cycle pulse per vsync
//   motion      in   4       {right, left, frame_idx[1:0]}
//   sprite_x    out  10      sprite left edge in pixels
//   frame_idx   out  2       displayed animation frame
//   facing      out  1       0 = right, 1 = left
//   mirror      out  1       renderer flips horizontally
//   rom_base    out  ADDR_W  first ROM word of the displayed frame
//   frame_valid out  1       one-cycle pulse on every commit
// ---------------------------------------------------------------------------
module sprite_frame_decoder #(
    parameter int HOLD_FRAMES = 4,
    parameter int STEP        = 2,
    parameter int X_INIT      = 320,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 623,
    parameter int FRAME_WORDS = 256,
    parameter int ADDR_W      = 12
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_tick,
    input  logic [3:0]        motion,
    output logic [9:0]        sprite_x,
    output logic [1:0]        frame_idx,
    output logic              facing,
    output logic              mirror,
    output logic [ADDR_W-1:0] rom_base,
    output logic              frame_valid
);

    localparam logic [3:0] HOLD_MAX = 4'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, DECODE, COMMIT} state_t;

    state_t            state_q, state_d;
    logic [3:0]        m_q, m_d;
    logic [3:0]        hold_cnt_q, hold_cnt_d;
    logic              hold_ok_q, hold_ok_d;
    logic [9:0]        x_q, x_d;
    logic [1:0]        idx_q, idx_d;
    logic              face_q, face_d;
    logic [ADDR_W-1:0] rom_q, rom_d;
    logic              fv_q, fv_d;

    logic              dir_valid;
    logic              dir_left;
    logic [2:0]        rom_sel;

    // Clamped horizontal step, evaluated 11 bits wide so neither edge wraps.
    function automatic logic [9:0] step_x(input logic [9:0] x, input logic left);
        logic [10:0] xe;
        logic [10:0] r;
        xe = {1'b0, x};
        if (left) begin
            if (xe < 11'(STEP) + 11'(X_MIN)) r = 11'(X_MIN);
            else                             r = xe - 11'(STEP);
        end else begin
            r = xe + 11'(STEP);
            if (r > 11'(X_MAX)) r = 11'(X_MAX);
        end
        return 10'(r);
    endfunction

    function automatic logic [ADDR_W-1:0] rom_word(input logic [2:0] sel);
        logic [31:0] w;
        w = 32'(sel) * 32'(FRAME_WORDS);
        return ADDR_W'(w);
    endfunction

    assign dir_valid = m_q[3] ^ m_q[2];
    assign dir_left  = m_q[2];

`ifdef SPRITE_MIRROR_EN
    assign rom_sel = {1'b0, m_q[1:0]};
    assign mirror  = face_q;
`else
    assign rom_sel = {dir_left, m_q[1:0]};
    assign mirror  = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        m_d        = m_q;
        hold_cnt_d = hold_cnt_q;
        hold_ok_d  = hold_ok_q;
        x_d        = x_q;
        idx_d      = idx_q;
        face_d     = face_q;
        rom_d      = rom_q;
        fv_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    m_d       = motion;
                    // The hold decision counts only ticks that elapsed
                    // before this one, so a fresh run commits on tick
                    // HOLD_FRAMES.
                    hold_ok_d = (hold_cnt_q == HOLD_MAX);
                    if (hold_cnt_q != HOLD_MAX) hold_cnt_d = hold_cnt_q + 4'd1;
                    state_d   = DECODE;
                end
            end
            DECODE: begin
                state_d = IDLE;
                // Commit results are loaded on the edge entering COMMIT so
                // they appear two cycles after the tick.
                if (dir_valid &&
                    ((dir_left != face_q) || ((m_q[1:0] != idx_q) && hold_ok_q))) begin
                    if (dir_left == face_q) x_d = step_x(x_q, dir_left);
                    face_d     = dir_left;
                    idx_d      = m_q[1:0];
                    rom_d      = rom_word(rom_sel);
                    fv_d       = 1'b1;
                    hold_cnt_d = 4'd0;
                    state_d    = COMMIT;
                end
            end
            COMMIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            m_q        <= 4'b1000;
            hold_cnt_q <= 4'd0;
            hold_ok_q  <= 1'b0;
            x_q        <= 10'(X_INIT);
            idx_q      <= 2'd0;
            face_q     <= 1'b0;
            rom_q      <= '0;
            fv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            hold_cnt_q <= hold_cnt_d;
            hold_ok_q  <= hold_ok_d;
            x_q        <= x_d;
            idx_q      <= idx_d;
            face_q     <= face_d;
            rom_q      <= rom_d;
            fv_q       <= fv_d;
        end
    end

    assign sprite_x    = x_q;
    assign frame_idx   = idx_q;
    assign facing      = face_q;
    assign rom_base    = rom_q;
    assign frame_valid = fv_q;

endmodule

// File: tb/tb_sprite_frame_decoder.sv
`timescale 1ns/1ps
module tb_sprite_frame_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic [3:0]  ma = 4'b1000, mb = 4'b1000, mc = 4'b1000;
    logic [9:0]  xa, xb, xc;
    logic [1:0]  ia, ib, ic;
    logic        fa, fb, fc, mra, mrb, mrc, va, vb, vc;
    logic [11:0] ra, rb, rc;

    always #5 clk = ~clk;

    sprite_frame_decoder dut (
        .Clk(clk), .Reset(rst), .frame_tick(tick), .motion(ma),
        .sprite_x(xa), .frame_idx(ia), .facing(fa), .mirror(mra),
        .rom_base(ra), .frame_valid(va));

    sprite_frame_decoder #(.HOLD_FRAMES(1), .X_INIT(1)) dut_lo (
        .Clk(clk), .Reset(rst), .frame_tick(tick), .motion(mb),
        .sprite_x(xb), .frame_idx(ib), .facing(fb), .mirror(mrb),
        .rom_base(rb), .frame_valid(vb));

    sprite_frame_decoder #(.HOLD_FRAMES(1), .X_INIT(622)) dut_hi (
        .Clk(clk), .Reset(rst), .frame_tick(tick), .motion(mc),
        .sprite_x(xc), .frame_idx(ic), .facing(fc), .mirror(mrc),
        .rom_base(rc), .frame_valid(vc));

    int n_checks = 0;
    int n_errors = 0;

    // Reference model of the main instance, updated once per accepted tick.
    int mx, midx, mface, mhold;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic int exp_rom();
`ifdef SPRITE_MIRROR_EN
        return midx * 256;
`else
        return (mface * 4 + midx) * 256;
`endif
    endfunction

    function automatic int exp_mirror();
`ifdef SPRITE_MIRROR_EN
        return mface;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        mx = 320; midx = 0; mface = 0; mhold = 0;
    endtask

    task automatic model_tick(input logic [3:0] m, output bit commit);
        bit ok;
        int nf;
        ok = (mhold == 3);
        if (mhold < 3) mhold++;
        commit = 1'b0;
        if (m[3:2] == 2'b10 || m[3:2] == 2'b01) begin
            nf = (m[3:2] == 2'b01) ? 1 : 0;
            if (nf != mface) begin
                mface = nf; midx = int'(m[1:0]); mhold = 0; commit = 1'b1;
            end else if (int'(m[1:0]) != midx && ok) begin
                midx = int'(m[1:0]); mhold = 0; commit = 1'b1;
                if (nf == 1) mx = (mx - 2 < 0) ? 0 : mx - 2;
                else         mx = (mx + 2 > 623) ? 623 : mx + 2;
            end
        end
    endtask

    task automatic check_outputs(input string ph);
        check_eq({ph, "_x"}, 32'(xa), mx);
        check_eq({ph, "_idx"}, 32'(ia), midx);
        check_eq({ph, "_facing"}, 32'(fa), mface);
        check_eq({ph, "_rom"}, 32'(ra), exp_rom());
        check_eq({ph, "_mirror"}, 32'(mra), exp_mirror());
    endtask

    task automatic do_reset();
        @(negedge clk);
        tick = 1'b0; ma = 4'b1000; mb = 4'b1000; mc = 4'b1000;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One accepted tick on all instances; checks the main one at T+2 and T+3.
    task automatic tick3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        bit commit;
        @(negedge clk);
        ma = a; mb = b; mc = c; tick = 1'b1;
        model_tick(a, commit);
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        check_eq("fv_commit", 32'(va), 32'(commit));
        check_outputs("t2");
        @(negedge clk);
        check_eq("fv_single", 32'(va), 0);
        check_outputs("t3");
        mb = 4'b1000; mc = 4'b1000;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] dir;
        model_reset();
        do_reset();
        check_eq("rst_x", 32'(xa), 320);
        check_eq("rst_rom", 32'(ra), 0);
        check_eq("rst_idx", 32'(ia), 0);
        check_eq("rst_facing", 32'(fa), 0);
        check_eq("rst_mirror", 32'(mra), 0);
        check_eq("rst_fv", 32'(va), 0);
        check_eq("rst_x_lo", 32'(xb), 1);
        check_eq("rst_x_hi", 32'(xc), 622);

        repeat (3) tick3(4'b1000, 4'b1000, 4'b1000);
        check_eq("idle_x", 32'(xa), 320);

        // Hold: first commit on the fourth tick.
        do_reset();
        repeat (4) tick3(4'b1001, 4'b1000, 4'b1000);
        check_eq("hold_x", 32'(xa), 322);
        check_eq("hold_idx", 32'(ia), 1);
        check_eq("hold_rom", 32'(ra), 256);

        // Turn commits immediately and does not move.
        tick3(4'b0101, 4'b1000, 4'b1000);
        check_eq("turn_facing", 32'(fa), 1);
        check_eq("turn_x", 32'(xa), 322);
`ifdef SPRITE_MIRROR_EN
        check_eq("turn_rom", 32'(ra), 256);
        check_eq("turn_mirror", 32'(mra), 1);
`else
        check_eq("turn_rom", 32'(ra), 1280);
        check_eq("turn_mirror", 32'(mra), 0);
`endif

        // Invalid directions.
        tick3(4'b1100, 4'b1000, 4'b1000);
        tick3(4'b0000, 4'b1000, 4'b1000);
        tick3(4'b1110, 4'b1000, 4'b1000);

        // Clamping on the side instances.
        tick3(4'b0000, 4'b0110, 4'b1001);
        check_eq("lo_turn_x", 32'(xb), 1);
        check_eq("hi_clamp_x", 32'(xc), 623);
        tick3(4'b0000, 4'b0101, 4'b1010);
        check_eq("lo_clamp_x", 32'(xb), 0);
        check_eq("hi_stay_x", 32'(xc), 623);
        tick3(4'b0000, 4'b0110, 4'b1001);
        check_eq("lo_stay_x", 32'(xb), 0);
        check_eq("hi_stay2_x", 32'(xc), 623);

        // A tick arriving while in DECODE is ignored.
        do_reset();
        begin
            bit commit;
            @(negedge clk);
            ma = 4'b1000; tick = 1'b1;
            model_tick(4'b1000, commit);
            @(negedge clk);
            ma = 4'b0101;
            @(negedge clk);
            tick = 1'b0;
            repeat (3) begin
                check_eq("ign_fv", 32'(va), 0);
                check_eq("ign_facing", 32'(fa), 0);
                @(negedge clk);
            end
        end

        // Reset during COMMIT.
        do_reset();
        @(negedge clk);
        ma = 4'b0111; tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        check_eq("rc_fv", 32'(va), 1);
        check_eq("rc_facing", 32'(fa), 1);
        #1 rst = 1'b1;
        #1;
        check_eq("rc_async_fv", 32'(va), 0);
        check_eq("rc_async_facing", 32'(fa), 0);
        check_eq("rc_async_idx", 32'(ia), 0);
        check_eq("rc_async_rom", 32'(ra), 0);
        check_eq("rc_async_x", 32'(xa), 320);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (4) begin
            @(negedge clk);
            check_eq("rc_after_fv", 32'(va), 0);
            check_outputs("rc_after");
        end

        // Randomized run against the model.
        do_reset();
        dir = 2'b10;
        repeat (300) begin
            if ($urandom_range(0, 9) >= 8) dir = 2'($urandom_range(0, 3));
            else if (dir == 2'b00 || dir == 2'b11) dir = 2'b10;
            tick3({dir, 2'($urandom_range(0, 3))}, 4'b1000, 4'b1000);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
